// File: rtl/uart_tx_arbiter_if.sv
// AXI-Lite bundle between the TX arbiter and the UART slave port.
// Master drives addr/data/valids and response readies; slave the rest.
interface uart_tx_arbiter_if;
  logic [12:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [12:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding the UART TX FIFO over AXI-Lite.
// Ports: clk_i, rstn_i (async low), req_valid_i/req_data_i/req_last_i,
// req_ready_o (one-hot accept), busy_o, err_o (sticky), err_clr_i,
// m_axi_uart (AXI-Lite master). Polls status (AddrBase+8) until the
// TX FIFO is not full, then writes the byte to AddrBase+4.
// Optional: UART_ARB_LOCK_EN keeps the grant until req_last_i.
module uart_tx_arbiter #(
  parameter int          NumReq   = 2,
  parameter logic [12:0] AddrBase = 13'h0000,
  parameter int          PollGap  = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [NumReq*8-1:0]   req_data_i,
  input  logic [NumReq-1:0]     req_last_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic                  busy_o,
  output logic                  err_o,
  input  logic                  err_clr_i,
  uart_tx_arbiter_if.master     m_axi_uart
);

  localparam int IW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [12:0] TxAddr = AddrBase + 13'd4;
  localparam logic [12:0] StAddr = AddrBase + 13'd8;

  typedef enum logic [2:0] {
    IDLE, AR, R, GAP, WR, B
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last_grant;
  logic [7:0]      r_byte;
  logic [7:0]      r_gap_cnt;
  logic            r_err;
  logic            r_arvalid;
  logic            r_rready;
  logic            r_awvalid;
  logic            r_wvalid;
  logic            r_bready;
  logic [12:0]     r_araddr;
  logic [12:0]     r_awaddr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;

  logic [NumReq-1:0] w_elig;
  logic [NumReq-1:0] w_cand;
  logic [NumReq-1:0] w_gnt_oh;
  logic              w_any;
  logic              w_hi_found;
  logic [IW-1:0]     w_hi_idx;
  logic [IW-1:0]     w_lo_idx;
  logic [IW-1:0]     w_gnt;
  logic [7:0]        w_sel_data;
  logic              w_sel_last;
  logic              w_err_set;
  logic              w_aw_done;
  logic              w_w_done;

`ifdef UART_ARB_LOCK_EN
  logic              r_lock;
  logic [IW-1:0]     r_lock_id;

  always_comb begin
    w_elig = '1;
    if (r_lock) begin
      w_elig = '0;
      for (int i = 0; i < NumReq; i++) begin
        if (r_lock_id == IW'(i)) w_elig[i] = 1'b1;
      end
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last_i;
  assign w_elig = '1;
`endif

  assign w_cand = req_valid_i & w_elig;
  assign w_any  = |w_cand;

  // Lowest candidate above last_grant wins; otherwise wrap to the
  // lowest candidate overall. Descending loop lets lower indices win.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        if (IW'(i) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IW'(i);
        end else begin
          w_lo_idx   = IW'(i);
        end
      end
    end
    w_gnt = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_gnt_oh   = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_gnt == IW'(i)) begin
        w_gnt_oh[i] = w_any;
        w_sel_data  = req_data_i[i*8 +: 8];
        w_sel_last  = req_last_i[i];
      end
    end
  end

  // Gated by reset so no byte is popped while the capture flop is held.
  assign req_ready_o =
    w_gnt_oh & {NumReq{(r_state == IDLE) && rstn_i}};

  assign w_err_set =
    ((r_state == R) && m_axi_uart.rvalid &&
     (m_axi_uart.rresp != 2'b00)) ||
    ((r_state == B) && m_axi_uart.bvalid &&
     (m_axi_uart.bresp != 2'b00));

  assign w_aw_done = !r_awvalid || m_axi_uart.awready;
  assign w_w_done  = !r_wvalid  || m_axi_uart.wready;

  logic w_unused_rdata;
  assign w_unused_rdata =
    ^{m_axi_uart.rdata[31:4], m_axi_uart.rdata[2:0]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= IDLE;
      r_last_grant <= IW'(NumReq - 1);
      r_byte       <= '0;
      r_gap_cnt    <= '0;
      r_err        <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_araddr     <= '0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
`ifdef UART_ARB_LOCK_EN
      r_lock       <= 1'b0;
      r_lock_id    <= '0;
`endif
    end else begin
      // Set beats a simultaneous clear.
      r_err <= w_err_set | (r_err & ~err_clr_i);
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_byte       <= w_sel_data;
            r_last_grant <= w_gnt;
            r_araddr     <= StAddr;
            r_arvalid    <= 1'b1;
            r_state      <= AR;
`ifdef UART_ARB_LOCK_EN
            r_lock       <= ~w_sel_last;
            r_lock_id    <= w_gnt;
`endif
          end
        end
        AR: begin
          if (m_axi_uart.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= R;
          end
        end
        R: begin
          if (m_axi_uart.rvalid) begin
            r_rready <= 1'b0;
            if (m_axi_uart.rresp != 2'b00) begin
              r_state <= IDLE;
            end else if (m_axi_uart.rdata[3]) begin
              if (PollGap == 0) begin
                r_arvalid <= 1'b1;
                r_state   <= AR;
              end else begin
                r_gap_cnt <= '0;
                r_state   <= GAP;
              end
            end else begin
              r_awaddr  <= TxAddr;
              r_wdata   <= {24'h0, r_byte};
              r_wstrb   <= 4'b0001;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == 8'(PollGap - 1)) begin
            r_arvalid <= 1'b1;
            r_state   <= AR;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        WR: begin
          if (m_axi_uart.awready) r_awvalid <= 1'b0;
          if (m_axi_uart.wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= B;
          end
        end
        B: begin
          if (m_axi_uart.bvalid) begin
            r_bready <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o = (r_state != IDLE);
  assign err_o  = r_err;

  assign m_axi_uart.araddr  = r_araddr;
  assign m_axi_uart.arvalid = r_arvalid;
  assign m_axi_uart.rready  = r_rready;
  assign m_axi_uart.awaddr  = r_awaddr;
  assign m_axi_uart.awvalid = r_awvalid;
  assign m_axi_uart.wdata   = r_wdata;
  assign m_axi_uart.wstrb   = r_wstrb;
  assign m_axi_uart.wvalid  = r_wvalid;
  assign m_axi_uart.bready  = r_bready;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with an AXI-Lite UART model.
// Expected TX writes are queued by stimulus and popped by a monitor.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(
    .NumReq(2), .AddrBase(13'h0000), .PollGap(4)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn_i),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_last_i(req_last),
    .req_ready_o(req_ready),
    .busy_o(busy),
    .err_o(err),
    .err_clr_i(err_clr),
    .m_axi_uart(bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_wr = 0;
  int aw_t = 0;
  int w_t = 0;

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [7:0] sb_q[$];
  logic [7:0] status_q[$];
  int         ar_t[$];
  int         acc_t[$];

  logic       s_ar_hold = 1'b0;
  logic [1:0] s_rresp = 2'b00;
  logic [1:0] s_bresp = 2'b00;
  int         s_w_dly = 0;
  int         w_cnt = 0;
  logic       aw_got = 1'b0;
  logic       w_got = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART slave model
  assign bus.arready = !s_ar_hold;
  assign bus.awready = 1'b1;
  assign bus.wready  = bus.wvalid && (w_cnt >= s_w_dly);

  always @(posedge clk or negedge rstn_i) begin
    logic [7:0] st;
    logic       aw_n;
    logic       w_n;
    if (!rstn_i) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= '0;
      bus.bvalid <= 1'b0;
      bus.bresp  <= '0;
      w_cnt      <= 0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
    end else begin
      if (bus.arvalid && bus.arready) begin
        st = (status_q.size() != 0) ? status_q.pop_front() : 8'h00;
        bus.rvalid <= 1'b1;
        bus.rdata  <= {24'h0, st};
        bus.rresp  <= s_rresp;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
      if (bus.wvalid && bus.wready) w_cnt <= 0;
      else if (bus.wvalid) w_cnt <= w_cnt + 1;
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      aw_n = aw_got | (bus.awvalid & bus.awready);
      w_n  = w_got | (bus.wvalid & bus.wready);
      if (aw_n && w_n) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= s_bresp;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else begin
        aw_got <= aw_n;
        w_got  <= w_n;
      end
    end
  end

  // Monitor: compares every bus transfer against the scoreboard.
  always @(negedge clk) begin
    if (rstn_i) begin
      if (bus.arvalid && bus.arready) begin
        chk("araddr", {19'h0, bus.araddr}, 32'h008);
        ar_t.push_back(cyc);
      end
      if (bus.awvalid && bus.awready) begin
        chk("awaddr", {19'h0, bus.awaddr}, 32'h004);
        aw_t = cyc;
      end
      if (bus.wvalid && bus.wready) begin
        n_wr++;
        w_t = cyc;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got %0h expected none",
                   bus.wdata);
        end else begin
          chk("wdata", bus.wdata, {24'h0, sb_q.pop_front()});
          chk("wstrb", {28'h0, bus.wstrb}, 32'h1);
        end
      end
      if (req_ready != 2'b00) acc_t.push_back(cyc);
    end
  end

  // Requester driver: pops a source on its accept edge.
  initial begin
    logic [1:0] hs;
    forever begin
      @(posedge clk);
      hs = rstn_i ? (req_valid & req_ready) : 2'b00;
      #1;
      if (hs[0] && src0.size() != 0) void'(src0.pop_front());
      if (hs[1] && src1.size() != 0) void'(src1.pop_front());
      req_valid[0] = (src0.size() != 0);
      req_valid[1] = (src1.size() != 0);
      req_data[7:0]  = (src0.size() != 0) ? src0[0][7:0] : 8'h0;
      req_data[15:8] = (src1.size() != 0) ? src1[0][7:0] : 8'h0;
      req_last[0] = (src0.size() != 0) ? src0[0][8] : 1'b0;
      req_last[1] = (src1.size() != 0) ? src1[0][8] : 1'b0;
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (n < budget && !(sb_q.size() == 0 && src0.size() == 0 &&
           src1.size() == 0 && !busy && req_valid == 2'b00)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_timeout"}, {31'h0, n >= budget}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rstn_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", {31'h0, bus.arvalid}, 32'h0);
    chk("rst_awvalid", {31'h0, bus.awvalid}, 32'h0);
    chk("rst_wvalid", {31'h0, bus.wvalid}, 32'h0);
    chk("rst_rready", {31'h0, bus.rready}, 32'h0);
    chk("rst_bready", {31'h0, bus.bready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_araddr", {19'h0, bus.araddr}, 32'h0);
    @(negedge clk) rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // Single requester, back-to-back bytes: 5-cycle cadence.
    acc_t.delete();
    src0.push_back({1'b1, 8'h41});
    src0.push_back({1'b1, 8'h42});
    sb_q.push_back(8'h41);
    sb_q.push_back(8'h42);
    wait_idle("single", 100);
    chk("acc_count", acc_t.size(), 32'd2);
    if (acc_t.size() == 2)
      chk("acc_gap", acc_t[1] - acc_t[0], 32'd5);
    chk("single_err", {31'h0, err}, 32'h0);

    // Round-robin alternation from reset.
    do_reset();
    src0.push_back({1'b1, 8'hA0});
    src0.push_back({1'b1, 8'hA1});
    src1.push_back({1'b1, 8'hB0});
    src1.push_back({1'b1, 8'hB1});
    sb_q.push_back(8'hA0);
    sb_q.push_back(8'hB0);
    sb_q.push_back(8'hA1);
    sb_q.push_back(8'hB1);
    wait_idle("rr", 200);

    // TX FIFO full twice, then free: polls 6 cycles apart.
    ar_t.delete();
    wr0 = n_wr;
    status_q.push_back(8'h08);
    status_q.push_back(8'h08);
    status_q.push_back(8'h04);
    src0.push_back({1'b1, 8'h55});
    sb_q.push_back(8'h55);
    wait_idle("poll", 200);
    chk("poll_reads", ar_t.size(), 32'd3);
    if (ar_t.size() == 3) begin
      chk("poll_gap1", ar_t[1] - ar_t[0], 32'd6);
      chk("poll_gap2", ar_t[2] - ar_t[1], 32'd6);
    end
    chk("poll_writes", n_wr - wr0, 32'd1);

    // Write error with W lagging AW by 3 cycles.
    s_bresp = 2'b10;
    s_w_dly = 3;
    src0.push_back({1'b1, 8'h77});
    sb_q.push_back(8'h77);
    wait_idle("berr", 100);
    chk("aw_w_gap", w_t - aw_t, 32'd3);
    chk("berr_set", {31'h0, err}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("berr_sticky", {31'h0, err}, 32'h1);
    s_bresp = 2'b00;
    s_w_dly = 0;
    pulse_clr();
    chk("err_clear", {31'h0, err}, 32'h0);
    src1.push_back({1'b1, 8'h78});
    sb_q.push_back(8'h78);
    wait_idle("after_clr", 100);
    chk("after_clr_err", {31'h0, err}, 32'h0);

    // Read error drops the byte.
    s_rresp = 2'b10;
    wr0 = n_wr;
    src0.push_back({1'b1, 8'h99});
    wait_idle("rerr", 100);
    chk("rerr_set", {31'h0, err}, 32'h1);
    chk("rerr_no_write", n_wr - wr0, 32'd0);
    s_rresp = 2'b00;
    pulse_clr();

    // Reset while AR is stalled.
    s_ar_hold = 1'b1;
    src0.push_back({1'b1, 8'h10});
    n = 0;
    while (n < 50 && !bus.arvalid) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ar_stall_seen", {31'h0, bus.arvalid}, 32'h1);
    @(posedge clk);
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_mid_arvalid", {31'h0, bus.arvalid}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    s_ar_hold = 1'b0;
    @(negedge clk) rstn_i = 1'b1;
    @(posedge clk);
    #1;
    src1.push_back({1'b1, 8'hC1});
    src0.push_back({1'b1, 8'hC0});
    sb_q.push_back(8'hC0);
    sb_q.push_back(8'hC1);
    wait_idle("post_rst", 100);

`ifdef UART_ARB_LOCK_EN
    // Locked message is not interleaved.
    do_reset();
    src0.push_back({1'b0, 8'h48});
    src0.push_back({1'b0, 8'h49});
    src0.push_back({1'b1, 8'h0A});
    src1.push_back({1'b1, 8'h5A});
    sb_q.push_back(8'h48);
    sb_q.push_back(8'h49);
    sb_q.push_back(8'h0A);
    sb_q.push_back(8'h5A);
    wait_idle("lock", 200);
`endif

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
